mem_trigger_sequencer: RTL and testbench
========================================

# mem_trigger_sequencer

Memory-driven, multi-channel trigger sequencer for simulated-trigger playback. It fetches trigger entries from an external synchronous RAM with a fixed read latency. Each entry is a time value plus a channel mask. The block fires one-cycle trigger pulses on the selected channels when the time matches, in absolute or delta timing mode. It stops after a programmable number of triggers, and sits between the trigger-pattern RAM and the front-end trigger distribution.

## Interface

- `TIME_W`, 30, width of the time field and internal timer
- `ADDR_W`, 14, RAM address width and trigger counter width
- `NUM_CH`, 4, number of trigger output channels
- `MEM_LAT`, 2, RAM read latency in cycles (≥1)

- `clk`  in  1  system clock
- `reset_n`  in  1  reset; synchronous, active-low
- `start`  in  1  single-cycle pulse, begins a sequence (ignored while busy)
- `abort`  in  1  stops the sequence and returns to IDLE
- `mode_delta`  in  1  0 = absolute times since start, 1 = delta times since previous trigger; sampled at start
- `total_trigger`  in  ADDR_W  number of triggers to fire; sampled at start
- `rd_req`  out  1  RAM read strobe, one cycle per entry
- `rd_addr`  out  ADDR_W  RAM address; address 0 reserved, first entry at 1
- `rd_data`  in  NUM_CH+TIME_W  {ch_mask, time}, valid exactly MEM_LAT cycles after `rd_req`
- `trigger`  out  NUM_CH  one-cycle pulse equal to ch_mask of the firing entry
- `busy`  out  1  high from the cycle after `start` until done/abort
- `done`  out  1  one-cycle pulse when the last trigger completes
- `trigger_gen`  out  ADDR_W  triggers fired in current/last sequence
- `late`  out  1  pulses with `trigger` when the entry fired after its due time
- `late_sticky`  out  1  set by any `late`, cleared by `start` or reset

## Operation

- States: IDLE, FETCH, ARMED, DONE.
- IDLE + `start`:
  - latch mode and total; clear `trigger_gen`, `late_sticky`, timer.
  - If total = 0, go to DONE. Otherwise issue `rd_req` with `rd_addr`=1 and go to FETCH.
- FETCH: wait MEM_LAT cycles, latch `rd_data` into the entry register, go to ARMED.
- ARMED: fire when timer ≥ entry time.
  - On fire, `trigger`=ch_mask and `trigger_gen`+1.
  - `late`=1 if timer > time at fire.
  - If the new count equals total, go to DONE. Otherwise, in the same cycle, issue `rd_req` with `rd_addr`+1 and go to FETCH.
- DONE: `done`=1 for one cycle, then IDLE; `busy` drops in that same cycle.
- Timer:
  - Counts cycles since start: value 1 in the cycle after `start`.
  - In delta mode it is also reset so that its value is 1 in the cycle after each fire.
  - Saturates at all-ones; it never wraps.
- A ch_mask of 0 still counts as a trigger, with all `trigger` bits low.
- `abort` (any state except IDLE): go to IDLE next cycle, no `done`, no `trigger`. `rd_addr` clears to 0; `trigger_gen` holds.
- `start` and `abort` in the same cycle: abort wins, start dropped.
- `start` while busy: ignored.
- `trigger_gen` holds after DONE until the next accepted `start`.

## Timing

- Reset values (`reset_n`=0 at a clock edge): state IDLE; all outputs 0 (`rd_req`, `rd_addr`, `trigger`, `busy`, `done`, `trigger_gen`, `late`, `late_sticky`); timer 0.
- Reset mid-sequence: same as reset values; no `done`.
- Start pulse at cycle S:
  - first `rd_req` at S+1;
  - data latched at S+1+MEM_LAT;
  - first compare at S+2+MEM_LAT.
- Minimum on-time entry time:
  - absolute first entry: MEM_LAT+2;
  - delta entries: MEM_LAT+1.
  - Smaller values fire at the first compare cycle with `late`=1.
- Absolute mode: a time at or below the current timer fires at the first compare cycle, with `late` if strictly below.
- Delta mode: on-time triggers are spaced exactly d cycles apart.
- `done` occurs 1 cycle after the final `trigger`.

## Configuration

- `TRIG_LATE_FLAG_EN`
  - Defined: late detection logic is present; `late` and `late_sticky` behave as specified.
  - Undefined: the detection logic is removed and `late`/`late_sticky` are constant 0. All other behaviour is identical, including firing on timer ≥ time.

## Test plan

- Absolute, MEM_LAT=2, total=3, entries {1,10},{2,20},{4,30}:
  - `trigger` = 1, 2, 4 at timer 10, 20, 30;
  - `rd_addr` = 1, 2, 3;
  - `done` 1 cycle after the third trigger; `trigger_gen`=3; `late` never set.
- Delta, total=3, entries {1,5}×3 → triggers exactly 5 cycles apart, `late`=0.
- Delta, entry time 1 with MEM_LAT=2 → fires at timer 3 with `late`=1; `late_sticky` stays 1 until the next start.
- total=0 → no `rd_req`, no `trigger`; `done` at S+1; `trigger_gen`=0.
- Abort and start interactions:
  - `abort` after 2 of 5 triggers → IDLE next cycle, no `done`, `trigger_gen`=2;
  - a `start` while busy is ignored;
  - a simultaneous `start`+`abort` is dropped.
- `reset_n`=0 mid-FETCH → all outputs 0 next cycle; a subsequent start fetches from `rd_addr`=1 again.

Source files
------------

// File: rtl/mem_trigger_sequencer.sv
// mem_trigger_sequencer
// Plays back trigger entries stored in an external synchronous RAM. Each entry
// is {ch_mask, time}. When the internal timer reaches the entry time, a
// one-cycle pulse equal to ch_mask is driven on o_trigger. The timer counts
// from the start pulse (absolute mode) or from the previous fire (delta mode).
// The sequence stops after a latched number of triggers.
//
// Optional feature macro: TRIG_LATE_FLAG_EN
//   defined   -> late detection (o_late, o_late_sticky) is built
//   undefined -> o_late and o_late_sticky are tied to 0
//
// Handshake: o_rd_req is a one-cycle strobe that carries o_rd_addr in the same
// cycle; the RAM returns {ch_mask, time} on i_rd_data exactly MEM_LAT cycles
// later with no back-pressure. i_start is accepted only in IDLE and only when
// i_abort is low; i_abort takes effect in any non-IDLE state.
//
// Timing notes: the first read is issued from a register in the cycle after
// start. Follow-up reads are issued combinationally in the very cycle a trigger
// fires, so the entry register is refilled one cycle sooner than after start.
// r_lat_cnt therefore counts cycles since the read strobe, whichever path
// issued it, and the entry is captured when it equals MEM_LAT.
module mem_trigger_sequencer #(
  parameter int TIME_W  = 30,
  parameter int ADDR_W  = 14,
  parameter int NUM_CH  = 4,
  parameter int MEM_LAT = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic                     i_mode_delta,
  input  logic [ADDR_W-1:0]        i_total_trigger,
  output logic                     o_rd_req,
  output logic [ADDR_W-1:0]        o_rd_addr,
  input  logic [NUM_CH+TIME_W-1:0] i_rd_data,
  output logic [NUM_CH-1:0]        o_trigger,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDR_W-1:0]        o_trigger_gen,
  output logic                     o_late,
  output logic                     o_late_sticky,
  output logic [1:0]               o_dbg_state
);

  localparam int                LAT_W    = $clog2(MEM_LAT + 2);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ARMED = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [LAT_W-1:0]    r_lat_cnt;
  logic [TIME_W-1:0]   r_timer;
  logic [TIME_W-1:0]   r_entry_time;
  logic [NUM_CH-1:0]   r_entry_mask;
  logic                r_mode_delta;
  logic [ADDR_W-1:0]   r_total;
  logic [ADDR_W-1:0]   r_gen;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rd_req_first;

  logic                w_accept;
  logic                w_abort;
  logic                w_fire;
  logic                w_last;
  logic                w_fetch_next;
  logic                w_latch;
  logic                w_late;
  logic [ADDR_W-1:0]   w_gen_inc;
  logic [ADDR_W-1:0]   w_addr_inc;

  // Event decode shared by the FSM and the datapath registers
  always_comb begin
    w_accept     = (r_state == S_IDLE) && i_start && !i_abort;
    w_abort      = (r_state != S_IDLE) && i_abort;
    w_fire       = (r_state == S_ARMED) && !i_abort && (r_timer >= r_entry_time);
    w_gen_inc    = r_gen + ADDR_ONE;
    w_addr_inc   = r_addr + ADDR_ONE;
    w_last       = (w_gen_inc == r_total);
    w_fetch_next = w_fire && !w_last;
    w_latch      = (r_state == S_FETCH) && !i_abort && (r_lat_cnt == LAT_LAST);
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = (i_total_trigger == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (r_lat_cnt == LAT_LAST) begin
          w_next_state = S_ARMED;
        end
      end
      S_ARMED: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (w_fire) begin
          w_next_state = w_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Sequence configuration captured when a start is accepted
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_mode_delta <= 1'b0;
      r_total      <= '0;
    end else if (w_accept) begin
      r_mode_delta <= i_mode_delta;
      r_total      <= i_total_trigger;
    end
  end

  // Cycles elapsed since the current read strobe
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_lat_cnt <= '0;
    end else if (w_accept) begin
      r_lat_cnt <= '0;
    end else if (w_fetch_next) begin
      r_lat_cnt <= LAT_ONE;
    end else if (r_state == S_FETCH) begin
      r_lat_cnt <= r_lat_cnt + LAT_ONE;
    end
  end

  // Entry register loaded when the RAM data is due
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_entry_time <= '0;
      r_entry_mask <= '0;
    end else if (w_latch) begin
      r_entry_time <= i_rd_data[TIME_W-1:0];
      r_entry_mask <= i_rd_data[TIME_W +: NUM_CH];
    end
  end

  // Saturating timer: 1 the cycle after start, and after each fire in delta mode
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_timer <= '0;
    end else if (w_accept) begin
      r_timer <= TIME_ONE;
    end else if (w_fire && r_mode_delta) begin
      r_timer <= TIME_ONE;
    end else if ((r_state != S_IDLE) && (r_timer != '1)) begin
      r_timer <= r_timer + TIME_ONE;
    end
  end

  // Fired-trigger counter, holds after done/abort until the next start
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_gen <= '0;
    end else if (w_accept) begin
      r_gen <= '0;
    end else if (w_fire) begin
      r_gen <= w_gen_inc;
    end
  end

  // Current RAM address and the registered first read strobe
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_addr         <= '0;
      r_rd_req_first <= 1'b0;
    end else begin
      r_rd_req_first <= w_accept && (i_total_trigger != '0);
      if (w_accept) begin
        r_addr <= (i_total_trigger != '0) ? ADDR_ONE : '0;
      end else if (w_abort) begin
        r_addr <= '0;
      end else if (w_fetch_next) begin
        r_addr <= w_addr_inc;
      end
    end
  end

`ifdef TRIG_LATE_FLAG_EN
  logic r_late_sticky;

  assign w_late = w_fire && (r_timer > r_entry_time);

  // Sticky late flag, cleared only by an accepted start or reset
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_late_sticky <= 1'b0;
    end else if (w_accept) begin
      r_late_sticky <= 1'b0;
    end else if (w_late) begin
      r_late_sticky <= 1'b1;
    end
  end

  assign o_late_sticky = r_late_sticky;
`else
  assign w_late        = 1'b0;
  assign o_late_sticky = 1'b0;
`endif

  // Output drive: fire-cycle pulses are combinational so they line up with the
  // timer value that satisfied the compare
  always_comb begin
    o_rd_req      = r_rd_req_first || w_fetch_next;
    o_rd_addr     = w_fetch_next ? w_addr_inc : r_addr;
    o_trigger     = w_fire ? r_entry_mask : '0;
    o_late        = w_late;
    o_busy        = (r_state == S_FETCH) || (r_state == S_ARMED);
    o_done        = (r_state == S_DONE) && !i_abort;
    o_trigger_gen = r_gen;
    o_dbg_state   = r_state;
  end

endmodule

// File: tb/tb_mem_trigger_sequencer.sv
// Bench for mem_trigger_sequencer: directed sequences against a schedule model
// that derives fire cycles from the timing rules (start cycle, RAM latency,
// entry times), plus literal expectations for the test-plan scenarios.
module tb_mem_trigger_sequencer;

  localparam int TIME_W  = 30;
  localparam int ADDR_W  = 14;
  localparam int NUM_CH  = 4;
  localparam int MEM_LAT = 2;
  localparam int MAXC    = 800;
`ifdef TRIG_LATE_FLAG_EN
  localparam bit LATE_EN = 1'b1;
`else
  localparam bit LATE_EN = 1'b0;
`endif

  logic                     clk;
  logic                     reset_n;
  logic                     start;
  logic                     abort;
  logic                     mode_delta;
  logic [ADDR_W-1:0]        total_trigger;
  logic                     rd_req;
  logic [ADDR_W-1:0]        rd_addr;
  logic [NUM_CH+TIME_W-1:0] rd_data;
  logic [NUM_CH-1:0]        trigger;
  logic                     busy;
  logic                     done;
  logic [ADDR_W-1:0]        trigger_gen;
  logic                     late;
  logic                     late_sticky;
  logic [1:0]               dbg_state;

  mem_trigger_sequencer #(
    .TIME_W (TIME_W),
    .ADDR_W (ADDR_W),
    .NUM_CH (NUM_CH),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_start        (start),
    .i_abort        (abort),
    .i_mode_delta   (mode_delta),
    .i_total_trigger(total_trigger),
    .o_rd_req       (rd_req),
    .o_rd_addr      (rd_addr),
    .i_rd_data      (rd_data),
    .o_trigger      (trigger),
    .o_busy         (busy),
    .o_done         (done),
    .o_trigger_gen  (trigger_gen),
    .o_late         (late),
    .o_late_sticky  (late_sticky),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model with fixed read latency ----------------
  logic [NUM_CH-1:0]        mem_mask [16];
  logic [TIME_W-1:0]        mem_time [16];
  logic                     pipe_v   [MEM_LAT];
  logic [ADDR_W-1:0]        pipe_a   [MEM_LAT];
  logic [NUM_CH+TIME_W-1:0] junk;

  always @(posedge clk) begin
    pipe_v[0] <= rd_req;
    pipe_a[0] <= rd_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
    junk <= (NUM_CH+TIME_W)'({$urandom(), $urandom()});
  end

  assign rd_data = (pipe_v[MEM_LAT-1] === 1'b1)
                 ? {mem_mask[pipe_a[MEM_LAT-1][3:0]], mem_time[pipe_a[MEM_LAT-1][3:0]]}
                 : junk;

  // ---------------- expected per-cycle outputs ----------------
  logic [NUM_CH-1:0] e_trig    [MAXC];
  logic              e_late    [MAXC];
  logic              e_rdreq   [MAXC];
  logic              e_done    [MAXC];
  logic              e_busy    [MAXC];
  logic              e_sticky  [MAXC];
  logic              e_addr_chk[MAXC];
  logic [ADDR_W-1:0] e_addr    [MAXC];
  logic [ADDR_W-1:0] e_gen     [MAXC];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int obs_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60)
        $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      e_trig[c]     = '0;
      e_late[c]     = 1'b0;
      e_rdreq[c]    = 1'b0;
      e_done[c]     = 1'b0;
      e_busy[c]     = 1'b0;
      e_sticky[c]   = 1'b0;
      e_addr_chk[c] = 1'b0;
      e_addr[c]     = '0;
      e_gen[c]      = '0;
    end
  endtask

  // Schedule model: fire cycle = max(first possible compare, base + time),
  // where base is the start cycle (absolute) or the previous fire (delta).
  task automatic plan_seq(input int s, input bit delta, input int total, input int abort_at);
    int  f_prev;
    int  base;
    int  c;
    int  f;
    int  t;
    bit  lt;
    bit  sticky;
    clear_from(s + 1);
    if (total == 0) begin
      e_done[s+1] = 1'b1;
      return;
    end
    e_rdreq[s+1]    = 1'b1;
    e_addr[s+1]     = ADDR_W'(1);
    e_addr_chk[s+1] = 1'b1;
    f_prev = s;
    sticky = 1'b0;
    for (int k = 1; k <= total; k++) begin
      t = int'(mem_time[k]);
      if (k == 1) begin
        c    = s + 2 + MEM_LAT;
        base = s;
      end else begin
        c    = f_prev + MEM_LAT + 1;
        base = delta ? f_prev : s;
      end
      f = (base + t > c) ? base + t : c;
      if (abort_at >= 0 && f >= abort_at) break;
      lt        = (f - base) > t;
      e_trig[f] = mem_mask[k];
      e_late[f] = LATE_EN && lt;
      sticky    = sticky | (LATE_EN && lt);
      for (int cc = f + 1; cc < MAXC; cc++) begin
        e_gen[cc]    = ADDR_W'(k);
        e_sticky[cc] = sticky;
      end
      if (k < total) begin
        e_rdreq[f]    = 1'b1;
        e_addr[f]     = ADDR_W'(k + 1);
        e_addr_chk[f] = 1'b1;
      end
      f_prev = f;
    end
    if (abort_at >= 0) begin
      for (int cc = s + 1; cc <= abort_at; cc++) e_busy[cc] = 1'b1;
      e_addr[abort_at+1]     = '0;
      e_addr_chk[abort_at+1] = 1'b1;
    end else begin
      for (int cc = s + 1; cc <= f_prev; cc++) e_busy[cc] = 1'b1;
      e_done[f_prev+1] = 1'b1;
    end
  endtask

  task automatic model_reset(input int r);
    clear_from(r + 1);
    e_addr_chk[r+1] = 1'b1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check("trigger",     64'(trigger),     64'(e_trig[cyc]));
      check("late",        64'(late),        64'(e_late[cyc]));
      check("rd_req",      64'(rd_req),      64'(e_rdreq[cyc]));
      check("done",        64'(done),        64'(e_done[cyc]));
      check("busy",        64'(busy),        64'(e_busy[cyc]));
      check("trigger_gen", 64'(trigger_gen), 64'(e_gen[cyc]));
      check("late_sticky", 64'(late_sticky), 64'(e_sticky[cyc]));
      if (e_addr_chk[cyc]) check("rd_addr", 64'(rd_addr), 64'(e_addr[cyc]));
      if (trigger != '0) obs_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic set_entry(input int a, input int mask, input int t);
    mem_mask[a] = NUM_CH'(mask);
    mem_time[a] = TIME_W'(t);
  endtask

  task automatic do_start(input bit delta, input int total, input int abort_rel, output int s);
    s = cyc;
    obs_q.delete();
    plan_seq(s, delta, total, (abort_rel < 0) ? -1 : s + abort_rel);
    start         = 1'b1;
    mode_delta    = delta;
    total_trigger = ADDR_W'(total);
    next_cycle();
    start         = 1'b0;
    mode_delta    = 1'($urandom_range(0, 1));
    total_trigger = ADDR_W'($urandom_range(0, 15));
  endtask

  task automatic check_offsets(input string name, input int s);
    check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({name, "_cycle"}, 64'(obs_q[i] - s), 64'(exp_q[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    clear_from(0);
    for (int i = 0; i < 16; i++) set_entry(i, 0, 0);
    reset_n       = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    mode_delta    = 1'b0;
    total_trigger = '0;
    next_cycle();
    chk_en = 1'b1;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Absolute, three entries at 10/20/30
    set_entry(1, 1, 10);
    set_entry(2, 2, 20);
    set_entry(3, 4, 30);
    do_start(1'b0, 3, -1, s);
    check("t1_model_done_at_31", 64'(e_done[s+31]), 64'd1);
    wait_until(s + 36);
    exp_q = '{32'd10, 32'd20, 32'd30};
    check_offsets("t1_abs", s);
    check("t1_gen", 64'(trigger_gen), 64'd3);

    // Delta, three entries of 5 cycles each
    set_entry(1, 1, 5);
    set_entry(2, 1, 5);
    set_entry(3, 1, 5);
    do_start(1'b1, 3, -1, s);
    wait_until(s + 20);
    exp_q = '{32'd5, 32'd10, 32'd15};
    check_offsets("t2_delta", s);

    // Delta, second entry shorter than the refill time: fires at timer 3
    set_entry(1, 3, 5);
    set_entry(2, 2, 1);
    do_start(1'b1, 2, -1, s);
    check("t3_model_late", 64'(e_late[s+8]), 64'(LATE_EN));
    wait_until(s + 14);
    exp_q = '{32'd5, 32'd8};
    check_offsets("t3_delta_late", s);
    check("t3_sticky", 64'(late_sticky), 64'(LATE_EN));

    // Absolute: time 1 (late at first compare), then mask 0 due exactly on time
    set_entry(1, 8, 1);
    set_entry(2, 0, 7);
    do_start(1'b0, 2, -1, s);
    wait_until(s + 12);
    exp_q = '{32'd4};
    check_offsets("t4_abs_late", s);
    check("t4_gen_mask0", 64'(trigger_gen), 64'd2);

    // total = 0: done the cycle after start, nothing fetched
    do_start(1'b0, 0, -1, s);
    wait_until(s + 4);
    check("t5_no_trigger", 64'(obs_q.size()), 64'd0);

    // Abort on the third fire cycle of five; a start while busy is ignored
    set_entry(1, 1, 10);
    set_entry(2, 2, 20);
    set_entry(3, 4, 30);
    set_entry(4, 8, 40);
    set_entry(5, 3, 50);
    do_start(1'b0, 5, 30, s);
    wait_until(s + 15);
    start         = 1'b1;
    mode_delta    = 1'b1;
    total_trigger = ADDR_W'(1);
    next_cycle();
    start         = 1'b0;
    wait_until(s + 30);
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    wait_until(s + 40);
    exp_q = '{32'd10, 32'd20};
    check_offsets("t6_abort", s);
    check("t6_gen", 64'(trigger_gen), 64'd2);

    // Simultaneous start and abort in IDLE is dropped
    start         = 1'b1;
    abort         = 1'b1;
    total_trigger = ADDR_W'(3);
    next_cycle();
    start = 1'b0;
    abort = 1'b0;
    wait_until(cyc + 5);
    check("t7_gen_held", 64'(trigger_gen), 64'd2);
    check("t7_idle", 64'(dbg_state), 64'd0);

    // Reset during FETCH, then a fresh sequence from address 1
    set_entry(1, 1, 10);
    set_entry(2, 2, 20);
    set_entry(3, 4, 30);
    do_start(1'b0, 3, -1, s);
    wait_until(s + 2);
    model_reset(s + 2);
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    check("t8_rst_state", 64'(dbg_state), 64'd0);
    check("t8_rst_addr", 64'(rd_addr), 64'd0);
    wait_until(s + 8);
    do_start(1'b0, 3, -1, s);
    check("t8_restart_req", 64'(rd_req), 64'd1);
    check("t8_restart_addr", 64'(rd_addr), 64'd1);
    wait_until(s + 36);
    exp_q = '{32'd10, 32'd20, 32'd30};
    check_offsets("t8_after_reset", s);
    check("t8_gen", 64'(trigger_gen), 64'd3);

    next_cycle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
